// File: rtl/pipeline_sequencer.sv
// Stall/flush sequencer for the 5-stage core: drives PC stop/enable and stage strobes.
// Optional perf counters (stall/flush/halt) are built when PIPELINE_SEQ_PERF_EN is defined.
module pipeline_sequencer #(
    parameter int FLUSH_CYCLES = 2
`ifdef PIPELINE_SEQ_PERF_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       br_valid,
    input  logic       br_taken,
    input  logic       load_use,
    input  logic       mem_busy,
    input  logic       halt_req,
    input  logic       resume,
    output logic       stop,
    output logic       enable,
    output logic       flush_if,
    output logic       flush_id,
    output logic       stall_id,
    output logic       halt_ack,
    output logic [2:0] state_o
`ifdef PIPELINE_SEQ_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt_tot,
    output logic [CNT_W-1:0] halt_cnt
`endif
);

    localparam logic [2:0] RUN     = 3'd0;
    localparam logic [2:0] FLUSH   = 3'd1;
    localparam logic [2:0] LDSTALL = 3'd2;
    localparam logic [2:0] MEMWAIT = 3'd3;
    localparam logic [2:0] HALTED  = 3'd4;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    logic [2:0] r_state;
    logic [2:0] r_flush_cnt;
    logic [2:0] w_state_nxt;
    logic [2:0] w_cnt_nxt;
    logic       w_taken;

    assign w_taken = br_valid & br_taken;
    assign state_o = r_state;

    always_comb begin
        stop        = 1'b0;
        enable      = 1'b0;
        flush_if    = 1'b0;
        flush_id    = 1'b0;
        stall_id    = 1'b0;
        halt_ack    = 1'b0;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_flush_cnt;
        if (rst) begin
            stop        = 1'b1;
            flush_if    = 1'b1;
            flush_id    = 1'b1;
            w_state_nxt = RUN;
            w_cnt_nxt   = 3'd0;
        end else begin
            case (r_state)
                RUN: begin
                    if (halt_req) begin
                        stop        = 1'b1;
                        w_state_nxt = HALTED;
                    end else if (mem_busy) begin
                        stop        = 1'b1;
                        stall_id    = 1'b1;
                        w_state_nxt = MEMWAIT;
                    end else if (w_taken) begin
                        enable      = 1'b1;
                        w_state_nxt = FLUSH;
                        w_cnt_nxt   = FLUSH_INIT;
                    end else if (load_use) begin
                        stop        = 1'b1;
                        stall_id    = 1'b1;
                        flush_id    = 1'b1;
                        w_state_nxt = LDSTALL;
                    end else begin
                        enable = br_valid;
                    end
                end
                FLUSH: begin
                    // wrong-path branches must never redirect while squashing
                    flush_if = 1'b1;
                    flush_id = 1'b1;
                    stop     = mem_busy;
                    if (!mem_busy) begin
                        if (r_flush_cnt == 3'd0) begin
                            w_state_nxt = halt_req ? HALTED : RUN;
                        end else begin
                            w_cnt_nxt = r_flush_cnt - 3'd1;
                        end
                    end
                end
                LDSTALL: begin
                    w_state_nxt = RUN;
                end
                MEMWAIT: begin
                    stop     = 1'b1;
                    stall_id = 1'b1;
                    if (!mem_busy) begin
                        w_state_nxt = halt_req ? HALTED : RUN;
                    end
                end
                HALTED: begin
                    stop     = 1'b1;
                    stall_id = 1'b1;
                    halt_ack = 1'b1;
                    if (resume && !halt_req) begin
                        w_state_nxt = RUN;
                    end
                end
                default: begin
                    stop        = 1'b1;
                    w_state_nxt = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        r_state     <= w_state_nxt;
        r_flush_cnt <= w_cnt_nxt;
    end

`ifdef PIPELINE_SEQ_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_tot;
    logic [CNT_W-1:0] r_halt_cnt;
    logic             w_flush_entry;

    assign w_flush_entry = (r_state == RUN) && (w_state_nxt == FLUSH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_tot <= '0;
            r_halt_cnt  <= '0;
        end else begin
            if (stall_id && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush_entry && (r_flush_tot != '1)) begin
                r_flush_tot <= r_flush_tot + 1'b1;
            end
            if ((r_state == HALTED) && (r_halt_cnt != '1)) begin
                r_halt_cnt <= r_halt_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt     = r_stall_cnt;
    assign flush_cnt_tot = r_flush_tot;
    assign halt_cnt      = r_halt_cnt;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer: a reference model queues expected
// outputs per cycle and they are popped and compared against the DUT.
module tb_pipeline_sequencer;

    localparam int FC = 2;
`ifdef PIPELINE_SEQ_PERF_EN
    localparam int CW = 4;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       br_valid = 1'b0;
    logic       br_taken = 1'b0;
    logic       load_use = 1'b0;
    logic       mem_busy = 1'b0;
    logic       halt_req = 1'b0;
    logic       resume = 1'b0;
    logic       stop, enable, flush_if, flush_id, stall_id, halt_ack;
    logic [2:0] state_o;
`ifdef PIPELINE_SEQ_PERF_EN
    logic [CW-1:0] stall_cnt, flush_cnt_tot, halt_cnt;
`endif

    always #5 clk = ~clk;

    pipeline_sequencer #(
        .FLUSH_CYCLES(FC)
`ifdef PIPELINE_SEQ_PERF_EN
        ,
        .CNT_W(CW)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .br_valid(br_valid),
        .br_taken(br_taken),
        .load_use(load_use),
        .mem_busy(mem_busy),
        .halt_req(halt_req),
        .resume(resume),
        .stop(stop),
        .enable(enable),
        .flush_if(flush_if),
        .flush_id(flush_id),
        .stall_id(stall_id),
        .halt_ack(halt_ack),
        .state_o(state_o)
`ifdef PIPELINE_SEQ_PERF_EN
        ,
        .stall_cnt(stall_cnt),
        .flush_cnt_tot(flush_cnt_tot),
        .halt_cnt(halt_cnt)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [2:0]  m_st = 3'd0;
    int          m_cnt = 0;
    int          m_stall = 0;
    int          m_ftot = 0;
    int          m_halt = 0;
    logic [8:0]  sb_q[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {stop,enable,flush_if,flush_id,stall_id,halt_ack,state}
    function automatic logic [8:0] model_out();
        logic s, e, fi, fd, sd, ha;
        s = 0; e = 0; fi = 0; fd = 0; sd = 0; ha = 0;
        if (rst) begin
            s = 1; fi = 1; fd = 1;
        end else begin
            case (m_st)
                3'd0: begin
                    if (halt_req) s = 1;
                    else if (mem_busy) begin s = 1; sd = 1; end
                    else if (br_valid && br_taken) e = 1;
                    else if (load_use) begin s = 1; sd = 1; fd = 1; end
                    else e = br_valid;
                end
                3'd1: begin fi = 1; fd = 1; s = mem_busy; end
                3'd3: begin s = 1; sd = 1; end
                3'd4: begin s = 1; sd = 1; ha = 1; end
                default: ;
            endcase
        end
        return {s, e, fi, fd, sd, ha, m_st};
    endfunction

    task automatic model_step(input logic sd);
        logic [2:0] prev;
        prev = m_st;
        if (rst) begin
            m_st = 0; m_cnt = 0;
            m_stall = 0; m_ftot = 0; m_halt = 0;
        end else begin
            if (sd) m_stall++;
            if (m_st == 3'd4) m_halt++;
            case (m_st)
                3'd0: begin
                    if (halt_req) m_st = 4;
                    else if (mem_busy) m_st = 3;
                    else if (br_valid && br_taken) begin
                        m_st = 1; m_cnt = FC - 1;
                    end else if (load_use) m_st = 2;
                end
                3'd1: if (!mem_busy) begin
                    if (m_cnt == 0) m_st = halt_req ? 3'd4 : 3'd0;
                    else m_cnt--;
                end
                3'd2: m_st = 0;
                3'd3: if (!mem_busy) m_st = halt_req ? 3'd4 : 3'd0;
                3'd4: if (resume && !halt_req) m_st = 0;
                default: m_st = 0;
            endcase
            if (prev == 3'd0 && m_st == 3'd1) m_ftot++;
        end
    endtask

    function automatic int sat(input int v);
`ifdef PIPELINE_SEQ_PERF_EN
        return (v > (1 << CW) - 1) ? (1 << CW) - 1 : v;
`else
        return v;
`endif
    endfunction

    // one cycle: inputs = {rst,bv,bt,lu,mb,hr,rs}
    task automatic cyc(input string tag, input logic [6:0] in);
        logic [8:0] e;
        {rst, br_valid, br_taken, load_use, mem_busy, halt_req, resume} = in;
        sb_q.push_back(model_out());
        #1;
        e = sb_q.pop_front();
        chk(tag, {23'd0, stop, enable, flush_if, flush_id, stall_id,
                  halt_ack, state_o}, {23'd0, e});
        chk({tag, "_excl"}, {31'd0, stop & enable}, 32'd0);
`ifdef PIPELINE_SEQ_PERF_EN
        chk({tag, "_pstall"}, 32'(stall_cnt), 32'(sat(m_stall)));
        chk({tag, "_pflush"}, 32'(flush_cnt_tot), 32'(sat(m_ftot)));
        chk({tag, "_phalt"}, 32'(halt_cnt), 32'(sat(m_halt)));
`endif
        @(posedge clk);
        model_step(e[4]);
        @(negedge clk);
    endtask

    localparam logic [6:0] IDLE = 7'b0000000;
    localparam logic [6:0] RST  = 7'b1000000;
    localparam logic [6:0] BR   = 7'b0110000;
    localparam logic [6:0] BRNT = 7'b0100000;
    localparam logic [6:0] LU   = 7'b0001000;
    localparam logic [6:0] MB   = 7'b0000100;
    localparam logic [6:0] HR   = 7'b0000010;
    localparam logic [6:0] RS   = 7'b0000001;

    initial begin
        @(posedge clk);
        @(negedge clk);
        // T1 reset with competing inputs
        repeat (3) cyc("T1_rst", RST | BR | MB);
        cyc("T1_rel", IDLE);
        // T2 taken branch then flush
        cyc("T2_br", BR);
        chk("T2_st", {29'd0, state_o}, 32'd1);
        repeat (3) cyc("T2_fl", IDLE);
        cyc("T2_nt", BRNT);
        // T3 load-use held 2 cycles
        cyc("T3_lu0", LU);
        cyc("T3_lu1", LU);
        cyc("T3_run", IDLE);
        // T4 mem wait mid-flush
        cyc("T4_br", BR);
        repeat (4) cyc("T4_mb", MB);
        repeat (3) cyc("T4_tail", IDLE);
        // T5 priority and resume
        cyc("T5_all", HR | MB | BR | LU);
        cyc("T5_h", HR);
        cyc("T5_rsig", HR | RS);
        cyc("T5_rs", RS);
        cyc("T5_run", IDLE);
        // halt deferred during flush
        cyc("DF_br", BR);
        repeat (3) cyc("DF_hr", HR);
        cyc("DF_rs", RS);
        // memwait exit to halted
        cyc("MW_0", MB);
        cyc("MW_1", MB | HR);
        cyc("MW_2", HR);
        cyc("MW_rs", RS);
        // reset mid-memwait and mid-flush
        cyc("RM_0", MB);
        cyc("RM_1", MB);
        cyc("RM_r", RST | MB);
        cyc("RM_br", BR);
        cyc("RM_r2", RST);
        cyc("RM_i", IDLE);
`ifdef PIPELINE_SEQ_PERF_EN
        // T6 halt counter saturation
        cyc("T6_h", HR);
        repeat (20) cyc("T6_hh", HR);
        chk("T6_sat", 32'(halt_cnt), 32'd15);
        cyc("T6_rs", RS);
`endif
        // random traffic, halt/resume kept sparse
        for (int i = 0; i < 400; i++) begin
            logic [6:0] v;
            v = 7'($urandom);
            v[6] = ($urandom_range(0, 49) == 0);
            v[1] = ($urandom_range(0, 9) == 0);
            v[0] = ($urandom_range(0, 3) == 0);
            cyc("RND", v);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
